// File: rtl/sbox_seq_pkg.sv
// Shared types and helpers for the masked S-box word sequencer.
package sbox_seq_pkg;

    localparam int BYTES_PER_WORD = 4;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } seq_state_e;

    // Fresh-randomness bits the masked S-box consumes per byte.
    // Each share pair needs 4 bits for each of Zmul1..3, 2 bits for each
    // of Zinv1..3 and 2 bits for each of Binv1..2.
    function automatic int rnd_w(input int shares);
        int pairs;
        pairs = (shares * (shares - 1)) / 2;
        return (3 * 4 * pairs) + (3 * 2 * pairs) + (2 * 2 * pairs);
    endfunction

    // Low bit of byte 'byte_idx' of share 'share' inside a shared word.
    function automatic int word_lane_lo(input int share, input int byte_idx);
        return (32 * share) + (8 * byte_idx);
    endfunction

    // Low bit of share 'share' inside a shared byte.
    function automatic int byte_lane_lo(input int share);
        return 8 * share;
    endfunction

endpackage

// File: rtl/sbox_word_sequencer_valid_pipe.sv
// In-flight tracker: one bit per S-box pipeline stage, set for real bytes
// and clear for bubbles, so the tap says when the S-box output is live.
module sbox_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    output logic o_tap
);

    logic [DEPTH-1:0] r_pipe;

    // Shift the issue flag along in step with the S-box pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= {DEPTH{1'b0}};
        end else begin
            r_pipe[0] <= i_push;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tap = r_pipe[DEPTH-1];

endmodule

// File: rtl/sbox_word_sequencer.sv
// Feeds one masked 32-bit word through the pipelined masked AES S-box a
// byte per cycle, forwards PRNG randomness alongside each byte and
// reassembles the substituted shares. Shares are never combined here.
module sbox_word_sequencer
    import sbox_seq_pkg::*;
#(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 4,
    parameter int RND_W        = rnd_w(SHARES)
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic [32*SHARES-1:0]  _WordxDI,
    input  logic                  WordValidxSI,
    output logic                  WordReadyxSO,
    input  logic [RND_W-1:0]      RndxDI,
    input  logic                  RndValidxSI,
    output logic                  RndReadyxSO,
    output logic [8*SHARES-1:0]   _SboxInxDO,
    output logic [RND_W-1:0]      SboxRndxDO,
    input  logic [8*SHARES-1:0]   _SboxOutxDI,
    output logic [32*SHARES-1:0]  _ResultxDO,
    output logic                  ResultValidxSO,
    input  logic                  ResultReadyxSI,
    output logic                  BusyxSO
);

    seq_state_e             r_state;
    logic [32*SHARES-1:0]   r_word_buf;
    logic [32*SHARES-1:0]   r_result;
    logic [2:0]             r_issue_cnt;
    logic [2:0]             r_collect_cnt;
    logic                   r_word_ready;
    logic                   r_rnd_ready;
    logic                   r_result_valid;
    logic                   r_busy;

    logic                   w_issue;
    logic                   w_collect;
    logic                   w_tap;
    logic [8*SHARES-1:0]    w_sbox_in;
    logic [RND_W-1:0]       w_sbox_rnd;

    // A byte is issued on every ISSUE cycle that has fresh randomness.
    always_comb begin
        w_issue = 1'b0;
        if ((r_state == ST_ISSUE) && RndValidxSI && (r_issue_cnt < 3'd4)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // A result byte is captured whenever the tracker says the S-box output is live.
    always_comb begin
        w_collect = 1'b0;
        if (((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && w_tap &&
            (r_collect_cnt < 3'd4)) begin
            w_collect = 1'b1;
        end else begin
            w_collect = 1'b0;
        end
    end

    // S-box operands: the current byte of every share plus fresh randomness, zero on bubbles.
    always_comb begin
        w_sbox_in  = {(8*SHARES){1'b0}};
        w_sbox_rnd = {RND_W{1'b0}};
        if (w_issue) begin
            for (int s = 0; s < SHARES; s++) begin
                w_sbox_in[byte_lane_lo(s) +: 8] =
                    r_word_buf[word_lane_lo(s, int'(r_issue_cnt[1:0])) +: 8];
            end
            w_sbox_rnd = RndxDI;
        end else begin
            w_sbox_in  = {(8*SHARES){1'b0}};
            w_sbox_rnd = {RND_W{1'b0}};
        end
    end

    sbox_valid_pipe #(
        .DEPTH (SBOX_LATENCY)
    ) u_valid_pipe (
        .i_clk   (ClkxCI),
        .i_rst_n (RstxBI),
        .i_push  (w_issue),
        .o_tap   (w_tap)
    );

    // Control FSM with registered handshakes, word buffer and result assembly.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_state        <= ST_IDLE;
            r_word_buf     <= {(32*SHARES){1'b0}};
            r_result       <= {(32*SHARES){1'b0}};
            r_issue_cnt    <= 3'd0;
            r_collect_cnt  <= 3'd0;
            r_word_ready   <= 1'b1;
            r_rnd_ready    <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            if (w_collect) begin
                for (int s = 0; s < SHARES; s++) begin
                    r_result[word_lane_lo(s, int'(r_collect_cnt[1:0])) +: 8] <=
                        _SboxOutxDI[byte_lane_lo(s) +: 8];
                end
                r_collect_cnt <= r_collect_cnt + 3'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (WordValidxSI && r_word_ready) begin
                        r_word_buf    <= _WordxDI;
                        r_issue_cnt   <= 3'd0;
                        r_collect_cnt <= 3'd0;
                        r_word_ready  <= 1'b0;
                        r_rnd_ready   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end else begin
                        r_word_ready  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue && (r_issue_cnt == 3'd3)) begin
                        r_rnd_ready <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_collect && (r_collect_cnt == 3'd3)) begin
                        r_result_valid <= 1'b1;
                        r_state        <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ResultReadyxSI) begin
                        r_result_valid <= 1'b0;
                        r_word_ready   <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_rnd_ready    <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_word_ready   <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign WordReadyxSO   = r_word_ready;
    assign RndReadyxSO    = r_rnd_ready;
    assign ResultValidxSO = r_result_valid;
    assign BusyxSO        = r_busy;
    assign _ResultxDO     = r_result;
    assign _SboxInxDO     = w_sbox_in;
    assign SboxRndxDO     = w_sbox_rnd;

endmodule

// File: tb/tb_sbox_word_sequencer.sv
// Scoreboard bench for sbox_word_sequencer with a behavioural 4-cycle
// masked S-box model; expected words come from an AES S-box table built
// from GF(2^8) inversion and the affine map.
module tb_sbox_word_sequencer;
    import sbox_seq_pkg::*;

    localparam int SHARES = 2;
    localparam int LAT    = 4;
    localparam int RW     = rnd_w(SHARES);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   word_in = 64'd0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic [RW-1:0] rnd_in = '0;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic [15:0]   sbox_in;
    logic [RW-1:0] sbox_rnd;
    logic [15:0]   sbox_out;
    logic [63:0]   result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_results = 0;
    int hs_cnt   = 0;
    int rr_high  = 0;
    int rr_run   = 0;
    int accept_cyc = 0;
    int first_valid_cyc = 0;
    int rnd_mode = 0;
    int rdy_mode = 1;
    logic prev_rv = 1'b0;
    logic [63:0] cur_word = 64'd0;
    logic [7:0]  sbox_tab [256];
    logic [31:0] exp_q [$];
    logic [15:0] sb_pipe [LAT];

    always #5 clk = ~clk;

    sbox_word_sequencer #(
        .SHARES       (SHARES),
        .SBOX_LATENCY (LAT),
        .RND_W        (RW)
    ) dut (
        .ClkxCI         (clk),
        .RstxBI         (rst_n),
        ._WordxDI       (word_in),
        .WordValidxSI   (word_valid),
        .WordReadyxSO   (word_ready),
        .RndxDI         (rnd_in),
        .RndValidxSI    (rnd_valid),
        .RndReadyxSO    (rnd_ready),
        ._SboxInxDO     (sbox_in),
        .SboxRndxDO     (sbox_rnd),
        ._SboxOutxDI    (sbox_out),
        ._ResultxDO     (result),
        .ResultValidxSO (result_valid),
        .ResultReadyxSI (result_ready),
        .BusyxSO        (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] ref_subword(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_tab[w[8*k +: 8]];
        return r;
    endfunction

    // Masked S-box stand-in: real output (remasked) only for handshaken bytes, junk otherwise.
    function automatic logic [15:0] sb_model(input logic [15:0] din, input logic hs);
        logic [7:0] m;
        logic [15:0] junk;
        m = 8'($urandom);
        junk = 16'($urandom);
        if (hs) return {m, sbox_tab[din[7:0] ^ din[15:8]] ^ m};
        return junk;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sb_pipe[0] <= sb_model(sbox_in, rnd_ready && rnd_valid);
        for (int i = 1; i < LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
    assign sbox_out = sb_pipe[LAT-1];

    // PRNG and result-consumer drivers.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) rr_run++; else rr_run = 0;
            case (rnd_mode)
                0:       rnd_valid = 1'b1;
                1:       rnd_valid = ((rr_run % 2) == 0);
                default: rnd_valid = 1'($urandom_range(0, 1));
            endcase
            rnd_in = RW'($urandom);
            case (rdy_mode)
                0:       result_ready = 1'b0;
                1:       result_ready = 1'b1;
                default: result_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: S-box port hygiene every cycle and scoreboard on each result handshake.
    initial begin
        logic [63:0] exp_in;
        int idx;
        forever begin
            @(negedge clk);
            if (rnd_ready && rnd_valid) begin
                idx = hs_cnt & 3;
                exp_in = 64'({cur_word[32 + 8*idx +: 8], cur_word[8*idx +: 8]});
                check("sbox_rnd_fwd", 64'(sbox_rnd), 64'(rnd_in));
                check("sbox_in_byte", 64'(sbox_in), exp_in);
                hs_cnt++;
            end else begin
                check("bubble_zero", 64'({sbox_in, sbox_rnd}), 64'd0);
            end
            if (rnd_ready) rr_high++;
            if (result_valid && !prev_rv) first_valid_cyc = cyc;
            prev_rv = result_valid;
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(result_valid), 64'd0);
                end else begin
                    check("result_word", 64'(result[31:0] ^ result[63:32]), 64'(exp_q.pop_front()));
                end
                n_results++;
            end
        end
    end

    task automatic send_word(input logic [63:0] w);
        int t;
        t = 0;
        while (!word_ready && t < 300) begin @(posedge clk); #1; t++; end
        if (!word_ready) begin
            check("word_ready_timeout", 64'(word_ready), 64'd1);
        end else begin
            word_in = w; word_valid = 1'b1; cur_word = w; hs_cnt = 0; rr_high = 0;
            @(posedge clk); #1;
            word_valid = 1'b0;
            word_in = {$urandom, $urandom};
            accept_cyc = cyc;
            exp_q.push_back(ref_subword(w[31:0] ^ w[63:32]));
        end
    endtask

    task automatic wait_result();
        int start;
        int t;
        start = n_results; t = 0;
        while (n_results == start && t < 300) begin @(posedge clk); #1; t++; end
        check("result_seen", 64'(n_results > start), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_ready"}, 64'(word_ready), 64'd1);
        check({tag, "_rnd_ready"}, 64'(rnd_ready), 64'd0);
        check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_result"}, result, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sbox_in"}, 64'({sbox_in, sbox_rnd}), 64'd0);
    endtask

    initial begin
        logic [31:0] m;
        logic [63:0] snap;
        int t;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_word_ready", 64'(word_ready), 64'd1);

        // Fixed word, one unmasked share, randomness always available.
        rnd_mode = 0; rdy_mode = 1;
        send_word({32'h0000_0000, 32'h0011_2233});
        wait_result();
        check("t1_latency", 64'(first_valid_cyc - accept_cyc + 1), 64'd9);
        check("t1_rnd_used", 64'(hs_cnt), 64'd4);

        // Randomly masked 0x53 bytes with randomness every other cycle.
        rnd_mode = 1;
        m = $urandom;
        send_word({m, m ^ 32'h5353_5353});
        wait_result();
        check("t2_issue_len", 64'(rr_high), 64'd8);
        check("t2_rnd_used", 64'(hs_cnt), 64'd4);

        // Consumer stalls with the result held.
        rnd_mode = 0; rdy_mode = 0;
        @(posedge clk); #1;
        send_word({$urandom, $urandom});
        t = 0;
        while (!result_valid && t < 100) begin @(posedge clk); #1; t++; end
        check("t3_valid_seen", 64'(result_valid), 64'd1);
        snap = result;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", 64'(result_valid), 64'd1);
            check("t3_hold_data", result, snap);
            check("t3_hold_wready", 64'(word_ready), 64'd0);
        end
        rdy_mode = 1;
        wait_result();
        @(posedge clk); #1;
        check("t3_valid_drop", 64'(result_valid), 64'd0);
        check("t3_back_idle", 64'({word_ready, busy}), 64'd2);

        // Reset after two bytes are in flight; the next word must be clean.
        send_word({$urandom, $urandom});
        t = 0;
        while (hs_cnt < 2 && t < 50) begin @(posedge clk); #1; t++; end
        check("t4_two_issued", 64'(hs_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4");
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        send_word({$urandom, $urandom});
        wait_result();

        // Random words, randomness stalls and consumer back-pressure.
        rnd_mode = 2; rdy_mode = 2;
        for (int i = 0; i < 1000; i++) send_word({$urandom, $urandom});
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
